// File: rtl/cache_types.sv
// Shared coherence message types for the snooping interconnect.
// Pure type/constant package: no logic, no latency.
// No flow control of its own; consumers define valid/ready usage.
package cache_types;

  localparam int NUM_CACHE = 8;
  localparam int XLEN      = 32;

  // GETS is encoded as zero so a cleared message reads back as GETS.
  typedef enum logic [1:0] {
    GETS = 2'd0,
    GETM = 2'd1,
    PUTM = 2'd2,
    IDLE = 2'd3
  } bus_tx_t;

  typedef struct packed {
    logic                       valid;
    logic [$clog2(NUM_CACHE):0] source;
    logic [XLEN-1:0]            addr;
    bus_tx_t                    bus_tx;
  } req_msg_t;

endpackage

// File: rtl/coherence_req_arbiter_pkg.sv
// Constants and helpers local to the request arbiter.
// Pure package: no logic, no latency.
// No flow control of its own.
package coherence_req_arbiter_pkg;

  import cache_types::*;

  localparam int REQ_FIFO_DEPTH = 2;

  // A requester competes only when it is valid and carries a real transaction.
  function automatic logic req_is_eligible(input logic valid, input bus_tx_t tx);
    return valid && (tx != IDLE);
  endfunction

endpackage

// File: rtl/req_msg_fifo.sv
// Synchronous FIFO of req_msg_t used as the arbiter's ordered output queue.
// Latency: a push at edge N is visible at head during cycle N+1 when empty.
// Backpressure: push ignored when full, pop ignored when empty; head held until popped.
module req_msg_fifo
  import cache_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  req_msg_t               push_msg,
  input  logic                   pop,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output req_msg_t               head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  req_msg_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & (count != '0);

  // Storage, pointers and occupancy; storage is cleared so an empty head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_msg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head presents the oldest entry; valid tracks occupancy rather than stored data.
  always_comb begin
    head       = mem[rd_ptr];
    head.valid = (count != '0);
  end

endmodule

// File: rtl/coherence_req_arbiter.sv
// Round-robin request arbiter feeding an ordered broadcast stream of req_msg_t.
// Latency: request accepted at edge N is on bus_req during cycle N+1 (empty queue).
// Backpressure: grants stop while the registered queue count is full; bus_ready never reaches req_ready.
module coherence_req_arbiter
  import cache_types::*;
  import coherence_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = NUM_CACHE,
  parameter int OUT_DEPTH = REQ_FIFO_DEPTH,
  parameter int SRC_W     = $clog2(NUM_CACHE) + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][XLEN-1:0]   req_addr,
  input  bus_tx_t [NUM_REQ-1:0]          req_tx,
  output logic [NUM_REQ-1:0]             req_ready,
  output req_msg_t                       bus_req,
  input  logic                           bus_ready,
  output logic [SRC_W-1:0]               grant_idx
);

  localparam int RR_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(OUT_DEPTH) + 1;

  logic [RR_W-1:0]    rr_ptr;
  logic [RR_W-1:0]    rr_nxt;
  logic [RR_W-1:0]    sel;
  logic               found;
  logic [NUM_REQ-1:0] eligible;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic [CNT_W-1:0]   fifo_count;
  req_msg_t           push_msg;

  // Eligibility mask: valid and not IDLE.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_is_eligible(req_valid[i], req_tx[i]);
    end
  end

  // Rotating priority search starting at rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!found && eligible[idx]) begin
        found = 1'b1;
        sel   = RR_W'(idx);
      end
    end
  end

  // Grant only into a non-full queue (registered count) and never while in reset.
  assign push   = found & ~fifo_full & rst_n;
  assign pop    = (fifo_count != '0) & bus_ready;
  assign rr_nxt = (sel == RR_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;

  // One-hot ready toward the granted requester.
  always_comb begin
    req_ready = '0;
    if (push) begin
      req_ready[sel] = 1'b1;
    end
  end

  // Message built from the granted requester, stamped with its index.
  always_comb begin
    push_msg                   = '0;
    push_msg.valid             = 1'b1;
    push_msg.source[RR_W-1:0]  = sel;
    push_msg.addr              = req_addr[sel];
    push_msg.bus_tx            = req_tx[sel];
  end

  // Pointer moves past the winner so it gets lowest priority next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      grant_idx <= '0;
    end else if (push) begin
      rr_ptr    <= rr_nxt;
      grant_idx <= SRC_W'(sel);
    end
  end

  req_msg_fifo #(
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_msg (push_msg),
    .pop      (pop),
    .full     (fifo_full),
    .count    (fifo_count),
    .head     (bus_req)
  );

endmodule

// File: tb/tb_coherence_req_arbiter.sv
// Self-checking bench for coherence_req_arbiter: queue-level model plus directed literal checks.
// Stimulus changes 1 time unit after the rising edge; model checks on the falling edge.
// Backpressure is exercised by holding bus_ready low until the queue fills.
module tb_coherence_req_arbiter;
  import cache_types::*;

  localparam int N     = 8;
  localparam int DEPTH = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [N-1:0]             req_valid;
  logic [N-1:0][XLEN-1:0]   req_addr;
  bus_tx_t [N-1:0]          req_tx;
  logic [N-1:0]             req_ready;
  req_msg_t                 bus_req;
  logic                     bus_ready;
  logic [3:0]               grant_idx;

  int n_chk  = 0;
  int n_fail = 0;

  coherence_req_arbiter #(
    .NUM_REQ   (N),
    .OUT_DEPTH (DEPTH),
    .SRC_W     (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_tx    (req_tx),
    .req_ready (req_ready),
    .bus_req   (bus_req),
    .bus_ready (bus_ready),
    .grant_idx (grant_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  req_msg_t mq[$];
  int       m_rr   = 0;
  int       m_gidx = 0;
  logic     exp_push = 1'b0;
  logic     exp_pop  = 1'b0;
  int       exp_sel  = 0;
  req_msg_t exp_msg;

  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    if (!rst_n) begin
      check("rst_bus_valid", 64'(bus_req.valid), 64'd0);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_grant_idx", 64'(grant_idx), 64'd0);
      check("rst_bus_addr", 64'(bus_req.addr), 64'd0);
      exp_push = 1'b0;
      exp_pop  = 1'b0;
    end else begin
      exp_push  = 1'b0;
      exp_ready = '0;
      if (mq.size() < DEPTH) begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m_rr + k) % N;
          if (!exp_push && req_valid[idx] && req_tx[idx] != IDLE) begin
            exp_push = 1'b1;
            exp_sel  = idx;
          end
        end
      end
      if (exp_push) exp_ready[exp_sel] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      check("bus_valid", 64'(bus_req.valid), 64'(mq.size() > 0));
      if (mq.size() > 0) begin
        check("bus_source", 64'(bus_req.source), 64'(mq[0].source));
        check("bus_addr", 64'(bus_req.addr), 64'(mq[0].addr));
        check("bus_tx", 64'(bus_req.bus_tx), 64'(mq[0].bus_tx));
      end
      check("grant_idx", 64'(grant_idx), 64'(m_gidx));
      exp_pop = bus_ready && (mq.size() > 0);
      if (exp_push) begin
        exp_msg        = '0;
        exp_msg.valid  = 1'b1;
        exp_msg.source = 4'(exp_sel);
        exp_msg.addr   = req_addr[exp_sel];
        exp_msg.bus_tx = req_tx[exp_sel];
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_rr   = 0;
      m_gidx = 0;
    end else begin
      if (exp_pop) void'(mq.pop_front());
      if (exp_push) begin
        mq.push_back(exp_msg);
        m_rr   = (exp_sel + 1) % N;
        m_gidx = exp_sel;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      req_tx[i]   = GETS;
      req_addr[i] = '0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    req_msg_t e;
    logic [N-1:0] oh;
    rst_n     = 1'b0;
    bus_ready = 1'b1;
    clear_reqs();
    req_valid = 8'hFF;
    tick();
    check("init_valid", 64'(bus_req.valid), 64'd0);
    check("init_ready", 64'(req_ready), 64'd0);
    check("init_src", 64'(bus_req.source), 64'd0);
    check("init_tx_gets", 64'(bus_req.bus_tx), 64'(GETS));
    check("init_rr_ptr", 64'(dut.rr_ptr), 64'd0);
    tick();
    clear_reqs();
    rst_n = 1'b1;
    tick();

    // Single request from requester 2.
    req_valid   = 8'h04;
    req_tx[2]   = GETM;
    req_addr[2] = 32'h1000;
    #1;
    check("single_ready", 64'(req_ready), 64'h04);
    tick();
    req_valid = '0;
    e        = '0;
    e.valid  = 1'b1;
    e.source = 4'd2;
    e.addr   = 32'h1000;
    e.bus_tx = GETM;
    check("single_msg", 64'(bus_req), 64'(e));
    check("single_rr_ptr", 64'(dut.rr_ptr), 64'd3);
    check("single_gidx", 64'(grant_idx), 64'd2);
    tick();

    // Round-robin with wrap, all requesters held valid.
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_tx[i]   = bus_tx_t'(2'(i % 3));
      req_addr[i] = 32'h100 * i;
    end
    req_valid = 8'hFF;
    #1;
    for (int k = 0; k < 9; k++) begin
      oh = 8'h01 << (k % 8);
      check("rr_ready", 64'(req_ready), 64'(oh));
      tick();
      check("rr_source", 64'(bus_req.source), 64'(k % 8));
    end
    req_valid = '0;
    tick();

    // Backpressure: requesters 1 and 5, then 3 waits while full.
    bus_ready   = 1'b0;
    req_tx[1]   = PUTM;
    req_addr[1] = 32'h2000;
    req_tx[5]   = GETS;
    req_addr[5] = 32'h5000;
    req_tx[3]   = GETM;
    req_addr[3] = 32'h3000;
    req_valid   = 8'h22;
    #1;
    check("bp_first", 64'(req_ready), 64'h02);
    tick();
    req_valid = 8'h20;
    #1;
    check("bp_second", 64'(req_ready), 64'h20);
    check("bp_head1", 64'(bus_req.source), 64'd1);
    tick();
    req_valid = 8'h08;
    #1;
    check("bp_full_block", 64'(req_ready), 64'h00);
    check("bp_head_hold", 64'(bus_req.source), 64'd1);
    tick();
    check("bp_full_block2", 64'(req_ready), 64'h00);
    check("bp_addr_hold", 64'(bus_req.addr), 64'h2000);
    bus_ready = 1'b1;
    #1;
    check("fullpop_nogrant", 64'(req_ready), 64'h00);
    tick();
    check("fullpop_head5", 64'(bus_req.source), 64'd5);
    check("fullpop_grant3", 64'(req_ready), 64'h08);
    tick();
    req_valid = '0;
    check("fullpop_head3", 64'(bus_req.source), 64'd3);
    tick();

    // IDLE filter: requester 0 is IDLE, requester 1 PUTM.
    req_tx[0]   = IDLE;
    req_tx[1]   = PUTM;
    req_addr[1] = 32'h1111;
    req_valid   = 8'h03;
    #1;
    check("idle_grant1", 64'(req_ready), 64'h02);
    tick();
    req_valid = 8'h01;
    check("idle_msg_tx", 64'(bus_req.bus_tx), 64'(PUTM));
    for (int k = 0; k < 3; k++) begin
      check("idle_never", 64'(req_ready[0]), 64'd0);
      tick();
    end
    req_valid = '0;
    req_tx[0] = GETS;
    tick();

    // Reset mid-stream with two entries queued (rr_ptr is 2 here).
    bus_ready   = 1'b0;
    req_tx[0]   = GETM;
    req_addr[0] = 32'hA0;
    req_tx[4]   = GETS;
    req_addr[4] = 32'hB0;
    req_tx[7]   = PUTM;
    req_addr[7] = 32'hC0;
    req_valid   = 8'h11;
    #1;
    check("mr_grant4", 64'(req_ready), 64'h10);
    tick();
    req_valid = 8'h01;
    #1;
    check("mr_grant0", 64'(req_ready), 64'h01);
    tick();
    req_valid = 8'h81;
    #1;
    check("mr_full_valid", 64'(bus_req.valid), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mr_async_valid", 64'(bus_req.valid), 64'd0);
    check("mr_async_ready", 64'(req_ready), 64'h00);
    tick();
    tick();
    rst_n     = 1'b1;
    bus_ready = 1'b1;
    #1;
    check("mr_post_ready", 64'(req_ready), 64'h01);
    check("mr_post_empty", 64'(bus_req.valid), 64'd0);
    tick();
    req_valid = '0;
    check("mr_post_src", 64'(bus_req.source), 64'd0);
    check("mr_post_addr", 64'(bus_req.addr), 64'hA0);
    check("mr_post_gidx", 64'(grant_idx), 64'd0);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/coherence_req_arbiter.md
# coherence_req_arbiter

Request-side arbiter of the snooping coherence interconnect. Collects `GETS`, `GETM` and `PUTM` requests from all L1 controllers (`NUM_CACHE` requesters). Grants at most one per cycle in round-robin order and stamps the source index. Delivers a totally ordered `req_msg_t` stream through a small output FIFO to the broadcast bus, which snoopers and the memory controller consume.

## Interface
Parameters:
- `NUM_REQ`, default `cache_types::NUM_CACHE` (8): number of requesters.
- `OUT_DEPTH`, default 2: output FIFO entries; must be a power of two and at least 2.
- `SRC_W`, default `$clog2(NUM_CACHE)+1` (4): source field width, matching `req_msg_t.source`.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  `NUM_REQ`  requester i has a request pending.
- `req_addr`  in  `NUM_REQ`×`XLEN`  request address per requester.
- `req_tx`  in  `NUM_REQ`×`bus_tx_t`  transaction type per requester.
- `req_ready`  out  `NUM_REQ`  one-hot or zero; the request is accepted when `req_valid[i] & req_ready[i]`.
- `bus_req`  out  `req_msg_t`  ordered broadcast message, taken from the FIFO head.
- `bus_ready`  in  1  consumer accepts `bus_req` this cycle.
- `grant_idx`  out  `SRC_W`  index of the last accepted requester (debug).

## Operation
- A request is eligible when `req_valid[i]=1` and `req_tx[i]!=IDLE`.
  - A request with `req_tx==IDLE` is never granted and never enqueued.
  - Its `req_ready` stays 0.
- Round-robin pointer `rr_ptr` (width `$clog2(NUM_REQ)`):
  - Search starts at `rr_ptr` and proceeds upward, wrapping from `NUM_REQ-1` to 0.
  - The first eligible index is granted.
- The grant is issued only when the FIFO is not full (`count<OUT_DEPTH`).
  - The full check uses the registered count only. There is no combinational path from `bus_ready` to `req_ready`.
- On accept:
  - Push `{valid=1, source=i, addr=req_addr[i], bus_tx=req_tx[i]}`.
  - Set `rr_ptr <= (i+1) mod NUM_REQ`.
  - Set `grant_idx <= i`.
- Pop: when `bus_req.valid & bus_ready`, the head advances.
- `count` update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
- Read and write pointers wrap modulo `OUT_DEPTH`.
- Requesters must hold `req_valid`, `req_addr` and `req_tx` stable until accepted. The arbiter does not check this.
- Fairness: each eligible requester is granted within `NUM_REQ` grants.

## Timing
- Reset (async assert, synchronous release) clears:
  - `rr_ptr=0`, `count=0`, FIFO pointers to 0, `grant_idx=0`.
  - `bus_req.valid=0`, `req_ready=0`.
  - `bus_req` addr, source and bus_tx read as 0 / `GETS` (storage cleared).
- Reset asserted mid-transfer discards all queued messages; no partial message is emitted after release.
- `req_ready` is combinational from `req_valid`, `req_tx`, `rr_ptr` and `count`.
- Latency: a request accepted at edge N appears on `bus_req` with `valid=1` after edge N, i.e. during cycle N+1, when the FIFO was empty.
- Throughput: one accept per cycle while `bus_ready=1`.
- Full FIFO with `bus_ready=1`: that cycle grants nothing. The grant resumes in the following cycle, so sustained throughput still requires `OUT_DEPTH≥2`.
- `bus_req` is held stable while `valid=1` and `bus_ready=0`.
- When `valid=0`, `bus_req` fields are don't-care, except that `valid` itself is 0.

## Structure
- `bus_tx_t`, `req_msg_t`, `NUM_CACHE` and `XLEN` come from package `cache_types`. No new package types are needed.
- Add a package constant `REQ_FIFO_DEPTH = 2` and use it as the default for `OUT_DEPTH`.
- One sub-module: `req_msg_fifo`.
  - Synchronous FIFO of `req_msg_t`, depth `OUT_DEPTH`.
  - Ports: `push`, `pop`, `full`, `count`, `head`.
- The arbiter logic (`rr_ptr`, priority search, eligibility mask) stays in the top module.

## Test plan
- Single request: after reset, `req_valid=8'h04`, `req_tx[2]=GETM`, addr `0x1000`, `bus_ready=1`.
  - `req_ready=8'h04` in the same cycle.
  - Next cycle `bus_req={1,src=2,0x1000,GETM}`.
  - `rr_ptr=3`.
- Round-robin with wrap: all 8 requesters valid and held, `bus_ready=1`.
  - Grants in order 0,1,…,7,0.
  - `bus_req.source` follows the same sequence one cycle later.
- Backpressure: `bus_ready=0`, requesters 1 and 5 valid.
  - Two accepts (1, then 5), then `req_ready=0` while full.
  - `bus_req` stays at src=1 unchanged.
  - Raising `bus_ready` pops src=1, then src=5, in order.
- IDLE filter: `req_valid=8'h03`, `req_tx[0]=IDLE`, `req_tx[1]=PUTM`.
  - Only requester 1 is granted.
  - Requester 0 never sees `req_ready=1`.
- Full plus pop: FIFO full and `bus_ready=1` in the same cycle.
  - No grant that cycle.
  - `count` drops to 1; the grant occurs in the next cycle.
- Reset mid-stream: assert `rst_n=0` with 2 entries queued.
  - `bus_req.valid` and `req_ready` go to 0 immediately (asynchronously).
  - After release, the first grant goes to requester 0 if it is valid.
